ppg_dg412_seq: RTL and testbench

Power and arm sequencer for a bank of DG412 clock-driver channels that share one DC-DC high-voltage rail. It collects per-channel run requests and enables the DC-DC converter. After soft-start and power-good it arms the requested channels. On release it drains the drivers and holds the rail up for a programmable hold-off before switching it off. It sits between the pattern-generator control registers and the per-channel driver `arm`/`armed` pins, and owns `dcdc_en`.

---
 rtl/ppg_dg412_seq.sv | 164 ++++++++++++++++
 tb/tb_ppg_dg412_seq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ppg_dg412_seq.sv
// Power and arm sequencer for a bank of DG412 clock-driver channels sharing
// one DC-DC high-voltage rail. Owns dcdc_en, soft-starts the rail, arms the
// requested channels once power is good, drains them on release and holds
// the rail up for a programmable hold-off before switching it off.
//
// Handshake note: req is a level, not a pulse; arm is a registered copy of
// req while ON, and armed_fb is the driver's acknowledgement. A channel is
// "ready" only when arm and armed_fb agree and the sequencer is ON.
//
// state_dbg encoding: 0 OFF, 1 SOFTSTART, 2 ON, 3 DRAIN, 4 HOLDOFF, 5 FAULT.
module ppg_dg412_seq #(
  parameter int NCH = 4,
  parameter int CW  = 16
) (
  input  logic           clk_fast,
  input  logic           rstn,
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  settle,
  input  logic [CW-1:0]  holdoff,
  input  logic           pgood,
  input  logic [NCH-1:0] armed_fb,
  input  logic           fault_clr,
  output logic           dcdc_en,
  output logic [NCH-1:0] arm,
  output logic [NCH-1:0] ready,
  output logic           fault,
  output logic           busy,
  output logic [2:0]     state_dbg
);

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_SOFTSTART = 3'd1,
    ST_ON        = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_HOLDOFF   = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            dcdc_en_q, dcdc_en_d;
  logic [NCH-1:0]  arm_q, arm_d;
  logic            fault_q, fault_d;

  logic            req_any;
  logic            fb_any;
  logic            cnt_zero;
  logic [CW-1:0]   cnt_dec;

  // Shared decode: any request, any driver still armed, saturating count-down.
  always_comb begin
    req_any  = |req;
    fb_any   = |armed_fb;
    cnt_zero = (cnt_q == '0);
    cnt_dec  = cnt_zero ? cnt_q : (cnt_q - CW'(1));
  end

  // State, counter and registered outputs; reset drops the rail at once.
  always_ff @(posedge clk_fast or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_OFF;
      cnt_q     <= '0;
      dcdc_en_q <= 1'b0;
      arm_q     <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dcdc_en_q <= dcdc_en_d;
      arm_q     <= arm_d;
      fault_q   <= fault_d;
    end
  end

  // Next-state and next-output logic; arm is low everywhere except ON.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dcdc_en_d = dcdc_en_q;
    arm_d     = '0;
    fault_d   = fault_q;

    unique case (state_q)
      ST_OFF: begin
        dcdc_en_d = 1'b0;
        if (req_any) begin
          state_d   = ST_SOFTSTART;
          cnt_d     = settle;
          dcdc_en_d = 1'b1;
        end
      end

      ST_SOFTSTART: begin
        dcdc_en_d = 1'b1;
        cnt_d     = cnt_dec;
        if (!req_any) begin
          // Released before the rail came up: treat like a normal release.
          state_d = ST_HOLDOFF;
          cnt_d   = holdoff;
        end else if (cnt_zero) begin
          state_d = pgood ? ST_ON : ST_FAULT;
        end
      end

      ST_ON: begin
        dcdc_en_d = 1'b1;
        arm_d     = req;
        if (!pgood) begin
          state_d = ST_FAULT;
        end else if (!req_any) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        dcdc_en_d = 1'b1;
        if (!pgood) begin
          state_d = ST_FAULT;
        end else if (!fb_any) begin
          state_d = ST_HOLDOFF;
          cnt_d   = holdoff;
        end
      end

      ST_HOLDOFF: begin
        // Rail is kept up; a new request goes straight back to ON.
        dcdc_en_d = 1'b1;
        cnt_d     = cnt_dec;
        if (req_any) begin
          state_d = ST_ON;
        end else if (cnt_zero) begin
          state_d   = ST_OFF;
          dcdc_en_d = 1'b0;
        end
      end

      ST_FAULT: begin
        dcdc_en_d = 1'b0;
        fault_d   = 1'b1;
        if (fault_clr && !req_any) begin
          state_d = ST_OFF;
          fault_d = 1'b0;
        end
      end

      default: begin
        state_d   = ST_OFF;
        dcdc_en_d = 1'b0;
      end
    endcase
  end

  // Output mapping.
  always_comb begin
    dcdc_en   = dcdc_en_q;
    arm       = arm_q;
    fault     = fault_q;
    busy      = (state_q != ST_OFF);
    ready     = arm_q & armed_fb & {NCH{state_q == ST_ON}};
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_ppg_dg412_seq.sv
// Bench for ppg_dg412_seq: a table of directed vectors plus hand-written
// sequences for brown-out, simultaneous events, drain gating and reset.
module tb_ppg_dg412_seq;

  localparam logic [2:0] S_OFF = 3'd0;
  localparam logic [2:0] S_SS  = 3'd1;
  localparam logic [2:0] S_ON  = 3'd2;
  localparam logic [2:0] S_DR  = 3'd3;
  localparam logic [2:0] S_HO  = 3'd4;
  localparam logic [2:0] S_FLT = 3'd5;

  logic        clk_fast = 1'b0;
  logic        rstn;
  logic [3:0]  req;
  logic [15:0] settle;
  logic [15:0] holdoff;
  logic        pgood;
  logic [3:0]  armed_fb;
  logic        fault_clr;
  logic        dcdc_en;
  logic [3:0]  arm;
  logic [3:0]  ready;
  logic        fault;
  logic        busy;
  logic [2:0]  state_dbg;

  logic [3:0]  hold_mask;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0]  req;
    logic        pg;
    logic        clr;
    logic [15:0] settle;
    logic [15:0] holdoff;
    int          n;
    logic [2:0]  st;
    logic        en;
    logic [3:0]  arm;
    logic [3:0]  rdy;
    logic        flt;
  } vec_t;

  vec_t vecs[$];

  ppg_dg412_seq #(.NCH(4), .CW(16)) dut (
    .clk_fast  (clk_fast),
    .rstn      (rstn),
    .req       (req),
    .settle    (settle),
    .holdoff   (holdoff),
    .pgood     (pgood),
    .armed_fb  (armed_fb),
    .fault_clr (fault_clr),
    .dcdc_en   (dcdc_en),
    .arm       (arm),
    .ready     (ready),
    .fault     (fault),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // Clock.
  always #5 clk_fast = ~clk_fast;

  // Driver-channel model: armed follows arm one cycle later; hold_mask
  // keeps selected channels reporting armed.
  always @(posedge clk_fast or negedge rstn) begin
    if (!rstn) armed_fb <= '0;
    else       armed_fb <= arm | hold_mask;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] st, input logic en,
                         input logic [3:0] a, input logic [3:0] r, input logic f);
    chk({tag, ".state"},   32'(state_dbg), 32'(st));
    chk({tag, ".dcdc_en"}, 32'(dcdc_en),   32'(en));
    chk({tag, ".arm"},     32'(arm),       32'(a));
    chk({tag, ".ready"},   32'(ready),     32'(r));
    chk({tag, ".fault"},   32'(fault),     32'(f));
    chk({tag, ".busy"},    32'(busy),      32'(st != S_OFF));
  endtask

  // Advance n rising edges, then land on the following falling edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk_fast);
    @(negedge clk_fast);
  endtask

  task automatic add(input logic [3:0] r, input logic pg, input logic clr,
                     input logic [15:0] s, input logic [15:0] h, input int n,
                     input logic [2:0] st, input logic en, input logic [3:0] a,
                     input logic [3:0] rd, input logic f);
    vec_t v;
    v.req = r; v.pg = pg; v.clr = clr; v.settle = s; v.holdoff = h; v.n = n;
    v.st = st; v.en = en; v.arm = a; v.rdy = rd; v.flt = f;
    vecs.push_back(v);
  endtask

  initial begin
    rstn = 1'b0; req = '0; settle = 16'd10; holdoff = 16'd5;
    pgood = 1'b1; fault_clr = 1'b0; hold_mask = '0;

    //  req     pg clr settle holdoff n   state  en arm     ready   flt
    // Basic sequence, settle=10, holdoff=5.
    add(4'b0000, 1, 0, 10, 5,  1, S_OFF, 0, 4'b0000, 4'b0000, 0);
    add(4'b0001, 1, 0, 10, 5,  1, S_SS,  1, 4'b0000, 4'b0000, 0);
    add(4'b0001, 1, 0, 10, 5, 10, S_SS,  1, 4'b0000, 4'b0000, 0);
    add(4'b0001, 1, 0, 10, 5,  1, S_ON,  1, 4'b0000, 4'b0000, 0);
    add(4'b0001, 1, 0, 10, 5,  1, S_ON,  1, 4'b0001, 4'b0000, 0);
    add(4'b0001, 1, 0, 10, 5,  1, S_ON,  1, 4'b0001, 4'b0001, 0);
    add(4'b0000, 1, 0, 10, 5,  1, S_DR,  1, 4'b0000, 4'b0000, 0);
    add(4'b0000, 1, 0, 10, 5,  1, S_DR,  1, 4'b0000, 4'b0000, 0);
    add(4'b0000, 1, 0, 10, 5,  1, S_HO,  1, 4'b0000, 4'b0000, 0);
    add(4'b0000, 1, 0, 10, 5,  5, S_HO,  1, 4'b0000, 4'b0000, 0);
    add(4'b0000, 1, 0, 10, 5,  1, S_OFF, 0, 4'b0000, 4'b0000, 0);
    // Re-request during hold-off at count 3.
    add(4'b0001, 1, 0, 10, 5, 13, S_ON,  1, 4'b0001, 4'b0000, 0);
    add(4'b0000, 1, 0, 10, 5,  3, S_HO,  1, 4'b0000, 4'b0000, 0);
    add(4'b0000, 1, 0, 10, 5,  2, S_HO,  1, 4'b0000, 4'b0000, 0);
    add(4'b0100, 1, 0, 10, 5,  1, S_ON,  1, 4'b0000, 4'b0000, 0);
    add(4'b0100, 1, 0, 10, 5,  1, S_ON,  1, 4'b0100, 4'b0000, 0);
    add(4'b0000, 1, 0, 10, 5,  3, S_HO,  1, 4'b0000, 4'b0000, 0);
    add(4'b0000, 1, 0, 10, 5,  6, S_OFF, 0, 4'b0000, 4'b0000, 0);
    // Soft-start failure, settle=4, pgood=0; clear ignored while req!=0.
    add(4'b0010, 0, 0,  4, 5,  1, S_SS,  1, 4'b0000, 4'b0000, 0);
    add(4'b0010, 0, 0,  4, 5,  4, S_SS,  1, 4'b0000, 4'b0000, 0);
    add(4'b0010, 0, 0,  4, 5,  1, S_FLT, 1, 4'b0000, 4'b0000, 0);
    add(4'b0010, 0, 0,  4, 5,  1, S_FLT, 0, 4'b0000, 4'b0000, 1);
    add(4'b0010, 0, 1,  4, 5,  1, S_FLT, 0, 4'b0000, 4'b0000, 1);
    add(4'b0000, 0, 0,  4, 5,  2, S_FLT, 0, 4'b0000, 4'b0000, 1);
    add(4'b0000, 0, 1,  4, 5,  1, S_OFF, 0, 4'b0000, 4'b0000, 0);
    add(4'b0000, 1, 0,  4, 5,  1, S_OFF, 0, 4'b0000, 4'b0000, 0);
    // settle=0, holdoff=0: one-cycle SOFTSTART and one-cycle HOLDOFF.
    add(4'b1000, 1, 0,  0, 0,  1, S_SS,  1, 4'b0000, 4'b0000, 0);
    add(4'b1000, 1, 0,  0, 0,  1, S_ON,  1, 4'b0000, 4'b0000, 0);
    add(4'b1000, 1, 0,  0, 0,  1, S_ON,  1, 4'b1000, 4'b0000, 0);
    add(4'b1000, 1, 0,  0, 0,  1, S_ON,  1, 4'b1000, 4'b1000, 0);
    add(4'b0000, 1, 0,  0, 0,  3, S_HO,  1, 4'b0000, 4'b0000, 0);
    add(4'b0000, 1, 0,  0, 0,  1, S_OFF, 0, 4'b0000, 4'b0000, 0);
    // Release during soft-start; pgood loss ignored in hold-off.
    add(4'b0001, 1, 0,  4, 2,  2, S_SS,  1, 4'b0000, 4'b0000, 0);
    add(4'b0000, 1, 0,  4, 2,  1, S_HO,  1, 4'b0000, 4'b0000, 0);
    add(4'b0000, 0, 0,  4, 2,  2, S_HO,  1, 4'b0000, 4'b0000, 0);
    add(4'b0000, 0, 0,  4, 2,  1, S_OFF, 0, 4'b0000, 4'b0000, 0);
    add(4'b0000, 1, 0,  4, 2,  1, S_OFF, 0, 4'b0000, 4'b0000, 0);

    // Reset state.
    step(2);
    chk_all("reset", S_OFF, 0, 4'b0000, 4'b0000, 0);
    rstn = 1'b1;
    step(0);

    for (int i = 0; i < vecs.size(); i++) begin
      req = vecs[i].req; pgood = vecs[i].pg; fault_clr = vecs[i].clr;
      settle = vecs[i].settle; holdoff = vecs[i].holdoff;
      step(vecs[i].n);
      chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].en, vecs[i].arm,
              vecs[i].rdy, vecs[i].flt);
    end
    fault_clr = 1'b0; pgood = 1'b1; req = '0;

    // Brown-out in ON: one-cycle pgood loss latches FAULT.
    settle = 16'd2; holdoff = 16'd3; req = 4'b1111;
    step(5);
    chk_all("bo_on", S_ON, 1, 4'b1111, 4'b0000, 0);
    step(2);
    chk_all("bo_run", S_ON, 1, 4'b1111, 4'b1111, 0);
    pgood = 1'b0;
    step(1);
    chk("bo_fault.state", 32'(state_dbg), 32'(S_FLT));
    pgood = 1'b1;
    step(1);
    chk_all("bo_off", S_FLT, 0, 4'b0000, 4'b0000, 1);
    step(5);
    chk_all("bo_hold", S_FLT, 0, 4'b0000, 4'b0000, 1);
    req = '0; fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    chk_all("bo_clr", S_OFF, 0, 4'b0000, 4'b0000, 0);

    // pgood loss and req drop in the same ON cycle.
    settle = 16'd0; req = 4'b0001;
    step(3);
    chk_all("sim_on", S_ON, 1, 4'b0001, 4'b0000, 0);
    req = '0; pgood = 1'b0;
    step(1);
    chk("sim_fault.state", 32'(state_dbg), 32'(S_FLT));
    pgood = 1'b1; fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    chk_all("sim_clr", S_OFF, 0, 4'b0000, 4'b0000, 0);

    // Drain gating: channel 2 keeps reporting armed for 20 cycles.
    settle = 16'd2; holdoff = 16'd3; req = 4'b1111;
    step(6);
    chk_all("dg_on", S_ON, 1, 4'b1111, 4'b1111, 0);
    req = '0; hold_mask = 4'b0100;
    for (int c = 0; c < 20; c++) begin
      step(1);
      chk($sformatf("dg_drain%0d.state", c), 32'(state_dbg), 32'(S_DR));
      chk($sformatf("dg_drain%0d.dcdc_en", c), 32'(dcdc_en), 32'd1);
    end
    hold_mask = '0;
    step(1);
    chk("dg_last.state", 32'(state_dbg), 32'(S_DR));
    step(1);
    chk_all("dg_ho", S_HO, 1, 4'b0000, 4'b0000, 0);
    begin
      int waited;
      waited = 0;
      while (state_dbg != S_OFF && waited < 10) begin
        step(1);
        waited++;
      end
      chk("dg_off_timeout", 32'(state_dbg), 32'(S_OFF));
      chk("dg_off_cycles", 32'(waited), 32'd4);
    end

    // Asynchronous reset during ON.
    settle = 16'd1; req = 4'b1111;
    step(4);
    chk_all("rst_on", S_ON, 1, 4'b1111, 4'b0000, 0);
    #2 rstn = 1'b0;
    #1;
    chk_all("rst_async", S_OFF, 0, 4'b0000, 4'b0000, 0);
    req = '0;
    @(negedge clk_fast);
    rstn = 1'b1;
    step(1);
    chk_all("rst_after", S_OFF, 0, 4'b0000, 4'b0000, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
